// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned PC_W_DEF        = 32;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned RST_CYCLES_DEF  = 1;
    localparam int unsigned MAX_CYCLES_DEF  = 300;
    localparam int unsigned STALL_LIMIT_DEF = 4;

    // Hold and streak counters only need to reach 255.
    localparam int unsigned HOLD_W   = 8;
    localparam int unsigned STREAK_W = 8;

endpackage

// File: rtl/run_ctrl_stall_det.sv
// PC-stall detector: flags the RUN cycle that completes STALL_LIMIT
// consecutive unchanged-pc comparisons.
module run_ctrl_stall_det
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [PC_W-1:0] pc,
    output logic            stall_c
);

    logic [PC_W-1:0]     prev_pc;
    logic                prev_vld;
    logic [STREAK_W-1:0] streak;
    logic                same_c;

    // No comparison until one RUN cycle has supplied a previous pc.
    assign same_c  = run && prev_vld && (pc == prev_pc);
    assign stall_c = same_c && (streak == STREAK_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            prev_vld <= 1'b0;
            streak   <= '0;
        end else begin
            prev_vld <= 1'b1;
            streak   <= same_c ? STREAK_W'(streak + STREAK_W'(1)) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc <= '0;
        end else if (run) begin
            prev_pc <= pc;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the processor in reset, runs it until halt, stall or
// cycle budget exhaustion. Stall detection is built only with RUN_CTRL_STALL_DET_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF,
    parameter int unsigned MAX_CYCLES  = MAX_CYCLES_DEF,
    parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_req,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  halt_pc
);

    // Elaboration-time parameter range checks.
    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst
        $error("run_ctrl: RST_CYCLES out of range");
    end
    if (STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_stall
        $error("run_ctrl: STALL_LIMIT out of range");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_max
        $error("run_ctrl: MAX_CYCLES out of range");
    end

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              cpu_reset_nxt, running_nxt, done_nxt, timeout_nxt;
    logic [CNT_W-1:0]  cycle_count_nxt, count_inc_c;
    logic [PC_W-1:0]   halt_pc_nxt;
    logic              stall_c;

`ifdef RUN_CTRL_STALL_DET_EN
    run_ctrl_stall_det #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_det (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_RUN),
        .pc      (pc),
        .stall_c (stall_c)
    );
`else
    assign stall_c = 1'b0;
`endif

    assign count_inc_c = CNT_W'(cycle_count + CNT_W'(1));

    // Next-state and next-output decode.
    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        cycle_count_nxt = cycle_count;
        timeout_nxt     = timeout;
        halt_pc_nxt     = halt_pc;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt       = ST_HOLD;
                    hold_cnt_nxt    = '0;
                    cycle_count_nxt = '0;
                    timeout_nxt     = 1'b0;
                    halt_pc_nxt     = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_cnt_nxt = HOLD_W'(hold_cnt + HOLD_W'(1));
                end
            end
            ST_RUN: begin
                cycle_count_nxt = count_inc_c;
                // Halt or stall outranks the budget check on the same edge.
                if (halt_req || stall_c) begin
                    state_nxt   = ST_DONE;
                    halt_pc_nxt = pc;
                end else if (count_inc_c == CNT_W'(MAX_CYCLES)) begin
                    state_nxt   = ST_DONE;
                    timeout_nxt = 1'b1;
                    halt_pc_nxt = pc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        cpu_reset_nxt = (state_nxt != ST_RUN);
        running_nxt   = (state_nxt == ST_RUN);
        done_nxt      = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            cpu_reset   <= cpu_reset_nxt;
            running     <= running_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            cycle_count <= cycle_count_nxt;
            halt_pc     <= halt_pc_nxt;
        end
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, 32: width of the observed program counter.
REQ-002 SHALL have parameter CNT_W, 16: width of the cycle counter.
REQ-003 SHALL have parameter RST_CYCLES, 1: number of cycles cpu_reset is held after start; legal range 1..255.
REQ-004 SHALL have parameter MAX_CYCLES, 300: RUN-cycle budget before timeout; legal range 1..2^CNT_W-1.
REQ-005 SHALL have parameter STALL_LIMIT, 4: consecutive unchanged-PC cycles that count as a halt; legal range 1..255.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: request to begin a run.
REQ-009 SHALL have port pc, input, PC_W: processor's current PC.
REQ-010 SHALL have port halt_req, input, 1: processor signals halt (ecall/ebreak decode).
REQ-011 SHALL have port cpu_reset, output, 1: reset driven to the processor.
REQ-012 SHALL have port running, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: high in DONE.
REQ-014 SHALL have port timeout, output, 1: run ended on budget exhaustion.
REQ-015 SHALL have port cycle_count, output, CNT_W: number of RUN cycles in the current or last run.
REQ-016 SHALL have port halt_pc, output, PC_W: pc sampled on the terminating cycle.

Function
REQ-017 SHALL implement FSM states IDLE, HOLD, RUN, DONE; cpu_reset=1 in IDLE, HOLD and DONE, 0 in RUN.
REQ-018 SHALL go IDLE->HOLD on an edge with start=1; clear cycle_count, timeout and halt_pc on that edge.
REQ-019 SHALL stay in HOLD for exactly RST_CYCLES cycles, then enter RUN.
REQ-020 SHALL increment cycle_count on every RUN edge, including the terminating edge.
REQ-021 SHALL go RUN->DONE on an edge where halt_req=1 or a stall is detected; capture halt_pc<=pc; timeout stays 0.
REQ-022 SHALL detect a stall when pc equals the previous RUN-cycle pc for STALL_LIMIT consecutive comparisons; the first RUN cycle performs no comparison; any pc change resets the streak.
REQ-023 SHALL go RUN->DONE with timeout<=1 on the edge where cycle_count+1 equals MAX_CYCLES and no halt or stall is present.
REQ-024 SHALL give halt/stall priority over timeout when they coincide; timeout=0.
REQ-025 SHALL ignore start in HOLD and RUN.
REQ-026 SHALL go DONE->HOLD on start=1, with the same clearing as REQ-018; otherwise hold done, timeout, cycle_count and halt_pc stable.
REQ-027 SHALL leave all outputs registered; no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, on an edge with reset=1, go to IDLE with cpu_reset=1, running=0, done=0, timeout=0, cycle_count=0, halt_pc=0 and stall streak=0, from any state including mid-RUN.
REQ-029 SHALL give reset priority over start on the same edge.

Configuration
REQ-030 SHALL, with RUN_CTRL_STALL_DET_EN defined, include PC-stall detection per REQ-022.
REQ-031 SHALL, without RUN_CTRL_STALL_DET_EN, remove the stall logic and previous-pc register; RUN ends only on halt_req or timeout.

Structure
REQ-032 SHALL define the FSM state typedef and the default constants for RST_CYCLES, MAX_CYCLES and STALL_LIMIT in package run_ctrl_pkg.
REQ-033 SHALL place stall detection (previous pc, streak counter, stall flag) in sub-module run_ctrl_stall_det, instantiated only under RUN_CTRL_STALL_DET_EN.

Verification
REQ-034 SHALL cover: RST_CYCLES=3, start pulse -> cpu_reset high exactly 3 cycles after HOLD entry, then running=1.
REQ-035 SHALL cover: halt_req=1 on 10th RUN cycle with pc=0x40 -> done=1, timeout=0, cycle_count=10, halt_pc=0x40.
REQ-036 SHALL cover: MAX_CYCLES=20, pc incrementing by 4, no halt -> done=1, timeout=1, cycle_count=20.
REQ-037 SHALL cover (macro defined): STALL_LIMIT=4, pc stuck at 0x1C from RUN cycle 5 -> DONE after 4 equal comparisons, cycle_count=9, halt_pc=0x1C; macro undefined -> runs to timeout.
REQ-038 SHALL cover: halt_req=1 on cycle MAX_CYCLES -> timeout=0; reset asserted mid-RUN -> next cycle IDLE, all outputs at reset values.
REQ-039 SHALL cover: start in DONE -> HOLD, cycle_count=0, timeout=0; start during RUN -> no effect.
